// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM state encodings,
// key-code field positions and the chatter LFSR feedback taps.
package keypad_pkg;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_BOUNCE_IN  = 3'd1;
    localparam state_t ST_HOLD       = 3'd2;
    localparam state_t ST_BOUNCE_OUT = 3'd3;
    localparam state_t ST_GAP        = 3'd4;

    // Key code layout: row index in the upper pair, column index in the lower pair.
    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    // Right-shifting Fibonacci LFSR: feedback is the XOR of bits 0,2,3,5,
    // which are the polynomial taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_ROW_MSB:KEY_ROW_LSB];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_COL_MSB:KEY_COL_LSB];
    endfunction

endpackage

// File: rtl/chatter_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the pseudo-random contact chatter.
// It only advances while enabled, so the sequence carries over between presses.
module chatter_lfsr
    import keypad_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic chatter
);

    logic [15:0] q;

    // Shift right, inserting the tap parity at the top, whenever enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            // NOTE: non-blocking so every flop samples the pre-edge value of q.
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

    assign chatter = q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: accepts press commands and replays them as a matrix-keypad
// contact (with optional chatter at make and break) on active-low Row lines,
// responding to the scanner's active-low Col drive.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned  BOUNCE_CYCLES = 16,
    parameter int unsigned  GAP_CYCLES    = 64,
    parameter logic [15:0]  LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic [3:0]  Col,
    output logic [3:0]  Row,
    output logic        key_down,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] BOUNCE_LEN = 16'(BOUNCE_CYCLES);
    localparam logic [15:0] GAP_LEN    = 16'(GAP_CYCLES);
    localparam bit          HAS_BOUNCE = (BOUNCE_CYCLES != 0);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] hold_len;
    logic [3:0]  key_q;
    logic        armed;
    logic        contact;
    logic        chatter;
    logic        lfsr_en;
    logic [15:0] phase_len;
    logic        phase_last;
    logic [15:0] cnt_inc;
    logic [3:0]  row_next;

    assign lfsr_en = (state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT);

    chatter_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (lfsr_en),
        .chatter (chatter)
    );

    // Length of the current phase and whether this is its final clock.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        phase_len = 16'd1;
        case (state)
            ST_BOUNCE_IN, ST_BOUNCE_OUT: phase_len = BOUNCE_LEN;
            ST_HOLD:                     phase_len = hold_len;
            ST_GAP:                      phase_len = GAP_LEN;
            default:                     phase_len = 16'd1;
        endcase
        phase_last = (cnt == phase_len - 16'd1);
        cnt_inc    = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end

    // Emulated contact: chatter while bouncing, solid closed while holding.
    always_comb begin
        contact = 1'b0;
        case (state)
            ST_BOUNCE_IN, ST_BOUNCE_OUT: contact = chatter;
            ST_HOLD:                     contact = 1'b1;
            default:                     contact = 1'b0;
        endcase
    end

    // Press sequencer: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hold_len <= '0;
            key_q    <= '0;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            if (state != ST_IDLE) begin
                cnt <= phase_last ? 16'd0 : cnt_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        key_q    <= cmd_key;
                        hold_len <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
                        cnt      <= '0;
                        state    <= HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                    end
                end
                ST_BOUNCE_IN: begin
                    if (phase_last) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (phase_last) state <= HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                end
                ST_BOUNCE_OUT: begin
                    if (phase_last) state <= ST_GAP;
                end
                ST_GAP: begin
                    if (phase_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pull the latched key's row low while closed and its column is driven low.
    always_comb begin
        row_next = 4'hF;
        if (contact && !Col[key_col(key_q)]) begin
            row_next[key_row(key_q)] = 1'b0;
        end
    end

    // Register Row; the async reset releases the lines at once, even mid-press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Row <= 4'hF;
        end else begin
            Row <= row_next;
        end
    end

    assign cmd_ready = armed && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign key_down  = contact;

endmodule
